// File: rtl/map_matrix_scanner_pkg.sv
// Shared constants, FSM encoding and column helpers for the 5x7 map matrix scanner.
// Column data in a decoded map sits at bit col*7 + (row-1), column a = 0.
package map_matrix_scanner_pkg;

    localparam int NUM_COLS  = 5;
    localparam int NUM_ROWS  = 7;
    localparam int MAP_W     = 35;
    localparam int MAP_COUNT = 5;

    localparam logic [NUM_COLS-1:0] COL_BLANK = 5'b11111;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SCAN = 2'd1,
        ST_SWAP = 2'd2
    } scan_state_t;

    function automatic logic code_legal(input logic [2:0] code);
        return code < 3'(MAP_COUNT);
    endfunction

    function automatic logic [NUM_ROWS-1:0] col_slice(input logic [MAP_W-1:0] map,
                                                       input logic [2:0] col);
        case (col)
            3'd0:    return map[6:0];
            3'd1:    return map[13:7];
            3'd2:    return map[20:14];
            3'd3:    return map[27:21];
            default: return map[34:28];
        endcase
    endfunction

    function automatic logic [NUM_COLS-1:0] col_enable_n(input logic [2:0] col);
        return ~(5'b00001 << col);
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot timer: counts 0..DIV-1 and flags the last cycle of each slot.
// tick is combinational from the count; clr restarts the count at 0 on the next cycle.
module scan_prescaler #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;

    assign tick = (r_cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/map_matrix_scanner.sv
// Multiplexes a decoded 5x7 map onto one active-low column at a time, with a blank slot on map change.
// Optional cursor blink is built when CURSOR_BLINK_EN is defined.
module map_matrix_scanner
    import map_matrix_scanner_pkg::*;
#(
    parameter int CLK_DIV = 50000
`ifdef CURSOR_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 25
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                map_sel_valid,
    input  logic [2:0]          map_sel,
    output logic                map_sel_ready,
    output logic                map_sel_err,
    output logic [2:0]          dec_map_code,
    input  logic [MAP_W-1:0]    dec_map,
    output logic [NUM_COLS-1:0] col_n,
    output logic [NUM_ROWS-1:0] row,
    output logic                frame_start
`ifdef CURSOR_BLINK_EN
    ,
    input  logic                cursor_en,
    input  logic [2:0]          cursor_col,
    input  logic [2:0]          cursor_row
`endif
);

    scan_state_t         r_state, w_state_nxt;
    logic [2:0]          r_code, w_code_nxt;
    logic [2:0]          r_pend, w_pend_nxt;
    logic                r_pend_vld, w_pend_vld_nxt;
    logic                r_ready, w_ready_nxt;
    logic                r_err, w_err_nxt;
    logic [2:0]          r_col, w_col_nxt;
    logic [NUM_COLS-1:0] r_col_n, w_col_n_nxt;
    logic [NUM_ROWS-1:0] r_row, w_row_nxt;
    logic                r_fs, w_fs_nxt;
    logic                w_tick, w_clr, w_xfer, w_legal;
    logic [2:0]          w_load_col;
    logic [NUM_ROWS-1:0] w_slot_row;

    scan_prescaler #(.DIV(CLK_DIV)) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (w_clr),
        .tick (w_tick)
    );

    assign w_xfer  = map_sel_valid && r_ready;
    assign w_legal = code_legal(map_sel);
    // Leaving a SWAP slot always restarts at column a.
    assign w_load_col = (r_state == ST_SCAN && r_col != 3'd4) ? r_col + 3'd1 : 3'd0;

`ifdef CURSOR_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic          r_blink;
    logic [BW-1:0] r_frm;

    always_comb begin
        w_slot_row = col_slice(dec_map, w_load_col);
        if (cursor_en && r_blink && cursor_col == w_load_col && cursor_row != 3'd0) begin
            w_slot_row = w_slot_row ^ (7'd1 << (cursor_row - 3'd1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink <= 1'b0;
            r_frm   <= '0;
        end else if (w_fs_nxt) begin
            if (r_frm == BW'(BLINK_FRAMES - 1)) begin
                r_frm   <= '0;
                r_blink <= ~r_blink;
            end else begin
                r_frm <= r_frm + 1'b1;
            end
        end
    end
`else
    assign w_slot_row = col_slice(dec_map, w_load_col);
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_code_nxt     = r_code;
        w_pend_nxt     = r_pend;
        w_pend_vld_nxt = r_pend_vld;
        w_ready_nxt    = r_ready;
        w_err_nxt      = w_xfer && !w_legal;
        w_col_nxt      = r_col;
        w_col_n_nxt    = r_col_n;
        w_row_nxt      = r_row;
        w_fs_nxt       = 1'b0;
        w_clr          = 1'b0;
        case (r_state)
            ST_OFF: begin
                if (w_xfer && w_legal) begin
                    w_code_nxt  = map_sel;
                    w_state_nxt = ST_SWAP;
                    w_clr       = 1'b1;
                    w_col_nxt   = 3'd0;
                end
            end
            ST_SCAN, ST_SWAP: begin
                // New codes wait for the frame to finish so the old map is never torn.
                if (w_xfer && w_legal) begin
                    w_pend_nxt     = map_sel;
                    w_pend_vld_nxt = 1'b1;
                    w_ready_nxt    = 1'b0;
                end
                if (w_tick) begin
                    if (r_state == ST_SCAN && r_col == 3'd4 && r_pend_vld) begin
                        w_state_nxt    = ST_SWAP;
                        w_code_nxt     = r_pend;
                        w_pend_vld_nxt = 1'b0;
                        w_ready_nxt    = 1'b1;
                        w_col_nxt      = 3'd0;
                        w_col_n_nxt    = COL_BLANK;
                        w_row_nxt      = '0;
                    end else begin
                        w_state_nxt = ST_SCAN;
                        w_col_nxt   = w_load_col;
                        w_col_n_nxt = col_enable_n(w_load_col);
                        w_row_nxt   = w_slot_row;
                        w_fs_nxt    = (w_load_col == 3'd0);
                    end
                end
            end
            default: w_state_nxt = ST_OFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code     <= 3'd0;
            r_pend     <= 3'd0;
            r_pend_vld <= 1'b0;
            r_ready    <= 1'b1;
            r_err      <= 1'b0;
            r_col      <= 3'd0;
            r_col_n    <= COL_BLANK;
            r_row      <= '0;
            r_fs       <= 1'b0;
        end else begin
            r_code     <= w_code_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_ready    <= w_ready_nxt;
            r_err      <= w_err_nxt;
            r_col      <= w_col_nxt;
            r_col_n    <= w_col_n_nxt;
            r_row      <= w_row_nxt;
            r_fs       <= w_fs_nxt;
        end
    end

    assign map_sel_ready = r_ready;
    assign map_sel_err   = r_err;
    assign dec_map_code  = r_code;
    assign col_n         = r_col_n;
    assign row           = r_row;
    assign frame_start   = r_fs;

endmodule

// File: tb/tb_map_matrix_scanner.sv
// Directed bench for map_matrix_scanner with CLK_DIV=4 and a behavioural 5-map decoder beside it.
module tb_map_matrix_scanner;

    logic        clk;
    logic        rst_n;
    logic        map_sel_valid;
    logic [2:0]  map_sel;
    logic        map_sel_ready;
    logic        map_sel_err;
    logic [2:0]  dec_map_code;
    logic [34:0] dec_map;
    logic [4:0]  col_n;
    logic [6:0]  row;
    logic        frame_start;
`ifdef CURSOR_BLINK_EN
    logic        cursor_en;
    logic [2:0]  cursor_col;
    logic [2:0]  cursor_row;
`endif

    int n_checks = 0;
    int n_errors = 0;

    map_matrix_scanner #(
        .CLK_DIV(4)
`ifdef CURSOR_BLINK_EN
        ,
        .BLINK_FRAMES(2)
`endif
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .map_sel_valid(map_sel_valid),
        .map_sel      (map_sel),
        .map_sel_ready(map_sel_ready),
        .map_sel_err  (map_sel_err),
        .dec_map_code (dec_map_code),
        .dec_map      (dec_map),
        .col_n        (col_n),
        .row          (row),
        .frame_start  (frame_start)
`ifdef CURSOR_BLINK_EN
        ,
        .cursor_en    (cursor_en),
        .cursor_col   (cursor_col),
        .cursor_row   (cursor_row)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decoder stand-in, packed as {e, d, c, b, a}.
    always_comb begin
        case (dec_map_code)
            3'd0:    dec_map = {7'h41, 7'h2A, 7'h55, 7'h0F, 7'h70};
            3'd1:    dec_map = {7'h10, 7'h08, 7'h04, 7'h02, 7'h01};
            3'd2:    dec_map = {7'h44, 7'h33, 7'h22, 7'h11, 7'h7F};
            3'd3:    dec_map = {7'h63, 7'h63, 7'h63, 7'h63, 7'h63};
            3'd4:    dec_map = {7'h1C, 7'h1C, 7'h1C, 7'h1C, 7'h1C};
            default: dec_map = '0;
        endcase
    end

    localparam logic [4:0] C_A = 5'b11110, C_B = 5'b11101, C_C = 5'b11011,
                           C_D = 5'b10111, C_E = 5'b01111, C_BLANK = 5'b11111;

    // Lands on the first cycle of the next slot showing column 'want'.
    task automatic wait_col(input logic [4:0] want);
        int n;
        n = 0;
        while (col_n === want && n < 100) begin @(negedge clk); n++; end
        while (col_n !== want && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            n_checks++; n_errors++;
            $display("FAIL wait_col: timeout, col_n=%b required %b", col_n, want);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; map_sel_valid = 1'b0; map_sel = 3'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({col_n, row, map_sel_ready, map_sel_err, frame_start, dec_map_code} !== {C_BLANK, 7'd0, 1'b1, 1'b0, 1'b0, 3'd0}) begin
            n_errors++;
            $display("FAIL reset_values: col_n=%b row=%b rdy=%b err=%b fs=%b code=%0d", col_n, row, map_sel_ready, map_sel_err, frame_start, dec_map_code);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_checks++;
            if (col_n !== C_BLANK || row !== 7'd0 || map_sel_ready !== 1'b1 || frame_start !== 1'b0) begin
                n_errors++;
                $display("FAIL idle_dark cyc %0d: col_n=%b row=%b rdy=%b fs=%b required 11111/0/1/0", i, col_n, row, map_sel_ready, frame_start);
            end
        end
    endtask

    task automatic test_first_select;
        map_sel_valid = 1'b1; map_sel = 3'd0;
        @(negedge clk);
        map_sel_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (col_n !== C_BLANK || row !== 7'd0 || dec_map_code !== 3'd0) begin
                n_errors++;
                $display("FAIL first_blank cyc %0d: col_n=%b row=%b code=%0d required 11111/0/0", i, col_n, row, dec_map_code);
            end
            @(negedge clk);
        end
        n_checks++;
        if (col_n !== C_A || row !== 7'b1110000 || frame_start !== 1'b1) begin
            n_errors++;
            $display("FAIL first_col_a: col_n=%b row=%b fs=%b required 11110/1110000/1", col_n, row, frame_start);
        end
        @(negedge clk);
        n_checks++;
        if (frame_start !== 1'b0 || col_n !== C_A) begin
            n_errors++;
            $display("FAIL fs_one_cycle: fs=%b col_n=%b required 0/11110", frame_start, col_n);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (col_n !== C_B || row !== 7'h0F || frame_start !== 1'b0) begin
            n_errors++;
            $display("FAIL first_col_b: col_n=%b row=%h fs=%b required 11101/0f/0", col_n, row, frame_start);
        end
    endtask

    task automatic test_swap_map;
        wait_col(C_B);
        map_sel_valid = 1'b1; map_sel = 3'd2;
        @(negedge clk);
        map_sel_valid = 1'b0;
        n_checks++;
        if (map_sel_ready !== 1'b0 || dec_map_code !== 3'd0) begin
            n_errors++;
            $display("FAIL swap_ready_drop: rdy=%b code=%0d required 0/0", map_sel_ready, dec_map_code);
        end
        wait_col(C_C);
        n_checks++;
        if (row !== 7'h55 || map_sel_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL swap_old_c: row=%h rdy=%b required 55/0", row, map_sel_ready);
        end
        wait_col(C_D);
        n_checks++;
        if (row !== 7'h2A) begin
            n_errors++;
            $display("FAIL swap_old_d: row=%h required 2a", row);
        end
        wait_col(C_E);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (col_n !== C_E || row !== 7'h41 || map_sel_ready !== 1'b0 || dec_map_code !== 3'd0) begin
                n_errors++;
                $display("FAIL swap_old_e cyc %0d: col_n=%b row=%h rdy=%b code=%0d", i, col_n, row, map_sel_ready, dec_map_code);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (col_n !== C_BLANK || row !== 7'd0 || map_sel_ready !== 1'b1 || dec_map_code !== 3'd2) begin
                n_errors++;
                $display("FAIL swap_blank cyc %0d: col_n=%b row=%b rdy=%b code=%0d required 11111/0/1/2", i, col_n, row, map_sel_ready, dec_map_code);
            end
            @(negedge clk);
        end
        n_checks++;
        if (col_n !== C_A || row !== 7'b1111111 || frame_start !== 1'b1) begin
            n_errors++;
            $display("FAIL swap_new_a: col_n=%b row=%b fs=%b required 11110/1111111/1", col_n, row, frame_start);
        end
    endtask

    task automatic test_illegal_code;
        int blanks;
        wait_col(C_B);
        map_sel_valid = 1'b1; map_sel = 3'd6;
        @(negedge clk);
        map_sel_valid = 1'b0;
        n_checks++;
        if (map_sel_err !== 1'b1 || dec_map_code !== 3'd2 || map_sel_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL illegal_err: err=%b code=%0d rdy=%b required 1/2/1", map_sel_err, dec_map_code, map_sel_ready);
        end
        @(negedge clk);
        n_checks++;
        if (map_sel_err !== 1'b0) begin
            n_errors++;
            $display("FAIL illegal_err_pulse: err=%b required 0", map_sel_err);
        end
        blanks = 0;
        for (int i = 0; i < 30; i++) begin
            if (col_n === C_BLANK) blanks++;
            @(negedge clk);
        end
        n_checks++;
        if (blanks != 0 || dec_map_code !== 3'd2) begin
            n_errors++;
            $display("FAIL illegal_no_swap: blank cycles=%0d code=%0d required 0/2", blanks, dec_map_code);
        end
    endtask

    task automatic test_reselect;
        int n;
        wait_col(C_C);
        map_sel_valid = 1'b1; map_sel = 3'd2;
        @(negedge clk);
        map_sel_valid = 1'b0;
        n = 0;
        while (col_n !== C_BLANK && n < 40) begin @(negedge clk); n++; end
        n_checks++;
        if (col_n !== C_BLANK || dec_map_code !== 3'd2 || map_sel_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reselect_swap: col_n=%b code=%0d rdy=%b required 11111/2/1", col_n, dec_map_code, map_sel_ready);
        end
    endtask

    task automatic test_reset_mid_slot;
        wait_col(C_D);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (col_n !== C_BLANK || row !== 7'd0) begin
            n_errors++;
            $display("FAIL async_reset_blank: col_n=%b row=%b required 11111/0", col_n, row);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_checks++;
            if (col_n !== C_BLANK || dec_map_code !== 3'd0 || map_sel_ready !== 1'b1 || frame_start !== 1'b0) begin
                n_errors++;
                $display("FAIL after_reset_off cyc %0d: col_n=%b code=%0d rdy=%b fs=%b", i, col_n, dec_map_code, map_sel_ready, frame_start);
            end
        end
    endtask

`ifdef CURSOR_BLINK_EN
    task automatic test_cursor_blink;
        logic [6:0] exp_row;
        cursor_en = 1'b1; cursor_col = 3'd2; cursor_row = 3'd4;
        map_sel_valid = 1'b1; map_sel = 3'd0;
        @(negedge clk);
        map_sel_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            wait_col(C_A);
            wait_col(C_C);
            exp_row = (((k / 2) % 2) == 1) ? (7'h55 ^ 7'h08) : 7'h55;
            n_checks++;
            if (row !== exp_row) begin
                n_errors++;
                $display("FAIL cursor_frame %0d: row=%b required %b", k, row, exp_row);
            end
        end
        cursor_en = 1'b0;
    endtask
`endif

    initial begin
`ifdef CURSOR_BLINK_EN
        cursor_en = 1'b0; cursor_col = 3'd0; cursor_row = 3'd0;
`endif
        test_reset;
        test_first_select;
        test_swap_map;
        test_illegal_code;
        test_reselect;
        test_reset_mid_slot;
`ifdef CURSOR_BLINK_EN
        test_cursor_blink;
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
